mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
//
// PURPOSE
//   Shares the single dTLB/dCache memory-request port of the tile between two requesters:
//   req0 is the scalar core LSU and req1 is the vector memory unit.
//   - Grants the port round-robin and locks it to the owner until that owner's load or store completes.
//   - Routes the completion back to the owner; the load/store sequencer behind the port is unchanged.
//   - Drains killed operations and recovers from lost responses with a watchdog.
//
// PARAMETERS
//   ADDR_W       40    request address width
//   TIMEOUT_CYC  255   WAIT cycles before watchdog release (1..2^CNT_W-1)
//   CNT_W        8     watchdog counter width
//
// PORTS
//   clk              in   1       clock, rising edge
//   rst              in   1       reset, synchronous, active-low
//   req0_valid_i     in   1       scalar request pending (level, held until done0_o or kill)
//   req0_is_store_i  in   1       scalar request type, 1 = store
//   req0_addr_i      in   ADDR_W  scalar request address
//   req0_kill_i      in   1       scalar request flushed
//   req1_valid_i     in   1       vector request pending
//   req1_is_store_i  in   1       vector request type
//   req1_addr_i      in   ADDR_W  vector request address
//   req1_kill_i      in   1       vector request flushed
//   gnt_o            out  2       one-hot grant pulse, bit n = requester n
//   done_o           out  2       one-hot completion pulse to the owner
//   mem_valid_o      out  1       request strobe to the memory port
//   mem_is_store_o   out  1       latched request type
//   mem_addr_o       out  ADDR_W  latched request address
//   mem_owner_o      out  1       current owner (0 = scalar, 1 = vector)
//   ld_resp_valid_i  in   1       load response from dCache
//   st_resp_gnt_i    in   1       store grant from dCache
//   timeout_o        out  1       watchdog-release pulse
//
// BEHAVIOUR
//   Reset (rst=0 at posedge):
//     - Values: state=IDLE, rr_q=0 (req0 has priority), owner/addr/type regs=0, cnt=0, killed_q=0.
//     - All outputs are 0. The op in flight is abandoned; later stray responses are ignored in IDLE.
//   Kill gating: kill_n = reqn_kill_i, and a requester is eligible when reqn_valid_i & ~reqn_kill_i.
//   IDLE:
//     - Only one requester eligible: it wins.
//     - Both eligible: requester rr_q wins.
//     - On a win, latch owner, addr and is_store, then go to ISSUE.
//     - No eligible requester: stay in IDLE.
//   ISSUE (exactly 1 cycle):
//     - gnt_o[owner]=1 and mem_valid_o = ~kill_owner.
//     - kill_owner=1: return to IDLE with no op sent, and do not rotate rr_q.
//     - Otherwise go to WAIT with cnt=0 and killed_q=0.
//   WAIT:
//     - The matching response is ld_resp_valid_i when the latched type is a load, and st_resp_gnt_i when it is a store.
//     - Non-matching responses are ignored.
//     - kill_owner in WAIT sets killed_q; the arbiter keeps waiting, draining the in-flight op.
//     - Matching response: done_o[owner] = ~killed_q & ~kill_owner in the same cycle (combinational).
//       Then go to IDLE with rr_q <= ~owner.
//     - No response: cnt increments.
//       When cnt == TIMEOUT_CYC-1, pulse timeout_o for 1 cycle, go to IDLE, set rr_q <= ~owner and send no done.
//   Responses that arrive in IDLE or ISSUE are ignored.
//   Output stability:
//     - mem_addr_o, mem_is_store_o and mem_owner_o are stable from ISSUE through the last WAIT cycle.
//     - They hold their values in IDLE.
//     - gnt_o, done_o, mem_valid_o and timeout_o are 0 outside the states listed above.
//   Throughput: 3 cycles minimum per op (IDLE, ISSUE, WAIT with a response in the first WAIT cycle).
//   Fairness: with both requesters continuously valid, grants strictly alternate.
//
// TESTING
//   - Single request: reset, then req0 load @0x100.
//     Expect gnt_o=01 and mem_valid_o=1 with addr 0x100 in cycle 2.
//     ld_resp_valid_i in cycle 3 gives done_o=01 in the same cycle, then IDLE.
//   - Contention: req0 and req1 held valid for 4 ops.
//     Expect grant order 0,1,0,1 and one mem_valid_o per op.
//   - Kill in ISSUE: assert req1_kill_i during ISSUE.
//     Expect mem_valid_o=0 and a return to IDLE; rr_q is unchanged, so req1 regains priority next.
//   - Kill in WAIT: store outstanding, kill asserted, then st_resp_gnt_i 5 cycles later.
//     Expect done_o=00, exit from WAIT only on the gnt, and the next grant going to the other requester.
//   - Wrong response type: load outstanding and st_resp_gnt_i pulses.
//     Expect the arbiter to stay in WAIT and done_o=00.
//   - Watchdog and reset: with TIMEOUT_CYC=4 and no response, expect timeout_o in the 4th WAIT cycle, then IDLE.
//     Reset asserted mid-WAIT forces all outputs to 0 next cycle; a later ld_resp_valid_i is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the two requester ports, the shared memory-port request and the dCache
// responses of the scalar/vector memory-port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 40
);
    // requester 0: scalar core LSU
    logic              req0_valid_i;
    logic              req0_is_store_i;
    logic [ADDR_W-1:0] req0_addr_i;
    logic              req0_kill_i;
    // requester 1: vector memory unit
    logic              req1_valid_i;
    logic              req1_is_store_i;
    logic [ADDR_W-1:0] req1_addr_i;
    logic              req1_kill_i;
    // grant / completion back to the requesters
    logic [1:0]        gnt_o;
    logic [1:0]        done_o;
    // shared memory port
    logic              mem_valid_o;
    logic              mem_is_store_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_owner_o;
    logic              ld_resp_valid_i;
    logic              st_resp_gnt_i;
    logic              timeout_o;

    // Arbiter side.
    modport slave (
        input  req0_valid_i, req0_is_store_i, req0_addr_i, req0_kill_i,
        input  req1_valid_i, req1_is_store_i, req1_addr_i, req1_kill_i,
        input  ld_resp_valid_i, st_resp_gnt_i,
        output gnt_o, done_o, mem_valid_o, mem_is_store_o, mem_addr_o, mem_owner_o,
        output timeout_o
    );

    // Requester / dCache side.
    modport master (
        output req0_valid_i, req0_is_store_i, req0_addr_i, req0_kill_i,
        output req1_valid_i, req1_is_store_i, req1_addr_i, req1_kill_i,
        output ld_resp_valid_i, st_resp_gnt_i,
        input  gnt_o, done_o, mem_valid_o, mem_is_store_o, mem_addr_o, mem_owner_o,
        input  timeout_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the dTLB/dCache request port between the scalar LSU
// (requester 0) and the vector memory unit (requester 1). The port stays locked to
// its owner until the matching response, and a watchdog frees it if that response
// never arrives.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 40,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input logic          clk,
    input logic          rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              store_q, store_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              killed_q, killed_d;

    logic              elig0, elig1;
    logic              win;
    logic              kill_owner;
    logic              resp_match;
    logic [1:0]        owner_oh;
    logic [1:0]        gnt, done;
    logic              mem_valid;
    logic              timeout;

    assign elig0      = bus.req0_valid_i & ~bus.req0_kill_i;
    assign elig1      = bus.req1_valid_i & ~bus.req1_kill_i;
    // Tie goes to the round-robin pointer, otherwise to whoever is eligible.
    assign win        = (elig0 & elig1) ? rr_q : elig1;
    assign kill_owner = owner_q ? bus.req1_kill_i : bus.req0_kill_i;
    // Only the response type that matches the outstanding op can complete it.
    assign resp_match = store_q ? bus.st_resp_gnt_i : bus.ld_resp_valid_i;
    assign owner_oh   = owner_q ? 2'b10 : 2'b01;

    // State and latched-request registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            rr_q     <= 1'b0;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            store_q  <= 1'b0;
            cnt_q    <= '0;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            cnt_q    <= cnt_d;
            killed_q <= killed_d;
        end
    end

    // Next-state logic and the per-state strobes.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        store_d   = store_q;
        cnt_d     = cnt_q;
        killed_d  = killed_q;
        gnt       = 2'b00;
        done      = 2'b00;
        mem_valid = 1'b0;
        timeout   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (elig0 | elig1) begin
                    owner_d = win;
                    addr_d  = win ? bus.req1_addr_i : bus.req0_addr_i;
                    store_d = win ? bus.req1_is_store_i : bus.req0_is_store_i;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                gnt       = owner_oh;
                mem_valid = ~kill_owner;
                if (kill_owner) begin
                    // Nothing was sent, so the owner keeps its turn.
                    state_d = StIdle;
                end else begin
                    state_d  = StWait;
                    cnt_d    = '0;
                    killed_d = 1'b0;
                end
            end
            StWait: begin
                // A killed op is still drained; only its completion is suppressed.
                if (kill_owner) begin
                    killed_d = 1'b1;
                end
                if (resp_match) begin
                    done    = (~killed_q & ~kill_owner) ? owner_oh : 2'b00;
                    state_d = StIdle;
                    rr_d    = ~owner_q;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                    rr_d    = ~owner_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.gnt_o          = gnt;
    assign bus.done_o         = done;
    assign bus.mem_valid_o    = mem_valid;
    assign bus.timeout_o      = timeout;
    assign bus.mem_addr_o     = addr_q;
    assign bus.mem_is_store_o = store_q;
    assign bus.mem_owner_o    = owner_q;

endmodule
